// File: rtl/sdrc_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the SDRAM controller slave port.
// A grant is held for the whole cyc. An optional watchdog errors out accesses the slave never acks.
module sdrc_wb_arbiter #(
  parameter int AW     = 26,
  parameter int DW     = 32,
  parameter int SW     = DW / 8,
  parameter int TO_CYC = 256,
  parameter int CNT_W  = 9
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,

  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  input  logic          m0_we_i,
  input  logic [AW-1:0] m0_addr_i,
  input  logic [DW-1:0] m0_dat_i,
  input  logic [SW-1:0] m0_sel_i,
  input  logic [2:0]    m0_cti_i,
  output logic [DW-1:0] m0_dat_o,
  output logic          m0_ack_o,
  output logic          m0_err_o,

  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  input  logic          m1_we_i,
  input  logic [AW-1:0] m1_addr_i,
  input  logic [DW-1:0] m1_dat_i,
  input  logic [SW-1:0] m1_sel_i,
  input  logic [2:0]    m1_cti_i,
  output logic [DW-1:0] m1_dat_o,
  output logic          m1_ack_o,
  output logic          m1_err_o,

  output logic          s_cyc_o,
  output logic          s_stb_o,
  output logic          s_we_o,
  output logic [AW-1:0] s_addr_o,
  output logic [DW-1:0] s_dat_o,
  output logic [SW-1:0] s_sel_o,
  output logic [2:0]    s_cti_o,
  input  logic [DW-1:0] s_dat_i,
  input  logic          s_ack_i,

  output logic [1:0]    gnt_o,
  output logic          timeout_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GNT0   = 3'd1,
    GNT1   = 3'd2,
    DRAIN0 = 3'd3,
    DRAIN1 = 3'd4
  } state_t;

  localparam bit             WD_EN     = (TO_CYC > 0);
  localparam int             TO_LAST_I = (TO_CYC > 0) ? (TO_CYC - 1) : 0;
  localparam logic [CNT_W-1:0] TO_LAST = TO_LAST_I[CNT_W-1:0];

  state_t           state_r;
  state_t           state_nx_s;
  logic             last_gnt_r;
  logic [CNT_W-1:0] wd_cnt_r;
  logic             stb_act_s;
  logic             expire_s;

  // State register
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Owner of the most recently finished cycle; reset value lets master 0 win the first tie
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      last_gnt_r <= 1'b1;
    end else begin
      case (state_r)
        GNT0, DRAIN0: last_gnt_r <= m0_cyc_i ? last_gnt_r : 1'b0;
        GNT1, DRAIN1: last_gnt_r <= m1_cyc_i ? last_gnt_r : 1'b1;
        default:      last_gnt_r <= last_gnt_r;
      endcase
    end
  end

  // Strobe from the owning master that the slave has not yet acked
  always_comb begin
    stb_act_s = 1'b0;
    case (state_r)
      GNT0:    stb_act_s = m0_cyc_i & m0_stb_i;
      GNT1:    stb_act_s = m1_cyc_i & m1_stb_i;
      default: stb_act_s = 1'b0;
    endcase
  end

  // An ack arriving in the expiry cycle wins over the timeout
  assign expire_s = WD_EN && stb_act_s && !s_ack_i && (wd_cnt_r == TO_LAST);

  // Watchdog: counts consecutive un-acked strobe cycles within one grant
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wd_cnt_r <= '0;
    end else if (!WD_EN) begin
      wd_cnt_r <= '0;
    end else if (state_nx_s != state_r) begin
      wd_cnt_r <= '0;
    end else if (stb_act_s && !s_ack_i) begin
      wd_cnt_r <= wd_cnt_r + CNT_W'(1);
    end else begin
      wd_cnt_r <= '0;
    end
  end

  // Next-state logic: round-robin on ties, handover without an idle cycle
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_nx_s = last_gnt_r ? GNT0 : GNT1;
        end else if (m0_cyc_i) begin
          state_nx_s = GNT0;
        end else if (m1_cyc_i) begin
          state_nx_s = GNT1;
        end else begin
          state_nx_s = IDLE;
        end
      end
      GNT0: begin
        if (!m0_cyc_i) begin
          state_nx_s = m1_cyc_i ? GNT1 : IDLE;
        end else if (expire_s) begin
          state_nx_s = DRAIN0;
        end else begin
          state_nx_s = GNT0;
        end
      end
      GNT1: begin
        if (!m1_cyc_i) begin
          state_nx_s = m0_cyc_i ? GNT0 : IDLE;
        end else if (expire_s) begin
          state_nx_s = DRAIN1;
        end else begin
          state_nx_s = GNT1;
        end
      end
      DRAIN0: begin
        if (!m0_cyc_i) begin
          state_nx_s = m1_cyc_i ? GNT1 : IDLE;
        end else begin
          state_nx_s = DRAIN0;
        end
      end
      DRAIN1: begin
        if (!m1_cyc_i) begin
          state_nx_s = m0_cyc_i ? GNT0 : IDLE;
        end else begin
          state_nx_s = DRAIN1;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Output mux: combinational pass-through for the owner, zeros elsewhere and during reset
  always_comb begin
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_addr_o  = '0;
    s_dat_o   = '0;
    s_sel_o   = '0;
    s_cti_o   = 3'b000;
    m0_dat_o  = '0;
    m0_ack_o  = 1'b0;
    m0_err_o  = 1'b0;
    m1_dat_o  = '0;
    m1_ack_o  = 1'b0;
    m1_err_o  = 1'b0;
    gnt_o     = 2'b00;
    timeout_o = 1'b0;
    if (wb_rst_i) begin
      gnt_o = 2'b00;
    end else begin
      case (state_r)
        GNT0: begin
          s_cyc_o   = m0_cyc_i & ~expire_s;
          s_stb_o   = m0_stb_i & ~expire_s;
          s_we_o    = m0_we_i;
          s_addr_o  = m0_addr_i;
          s_dat_o   = m0_dat_i;
          s_sel_o   = m0_sel_i;
          s_cti_o   = m0_cti_i;
          m0_dat_o  = s_dat_i;
          m0_ack_o  = s_ack_i;
          m0_err_o  = expire_s;
          gnt_o     = 2'b01;
          timeout_o = expire_s;
        end
        GNT1: begin
          s_cyc_o   = m1_cyc_i & ~expire_s;
          s_stb_o   = m1_stb_i & ~expire_s;
          s_we_o    = m1_we_i;
          s_addr_o  = m1_addr_i;
          s_dat_o   = m1_dat_i;
          s_sel_o   = m1_sel_i;
          s_cti_o   = m1_cti_i;
          m1_dat_o  = s_dat_i;
          m1_ack_o  = s_ack_i;
          m1_err_o  = expire_s;
          gnt_o     = 2'b10;
          timeout_o = expire_s;
        end
        DRAIN0:  gnt_o = 2'b01;
        DRAIN1:  gnt_o = 2'b10;
        default: gnt_o = 2'b00;
      endcase
    end
  end

endmodule

// File: tb/tb_sdrc_wb_arbiter.sv
// Directed self-checking bench for sdrc_wb_arbiter (watchdog shortened to 16 cycles).
module tb_sdrc_wb_arbiter;
  localparam int AW = 26;
  localparam int DW = 32;
  localparam int SW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          wb_rst_i;
  logic          m0_cyc_i, m0_stb_i, m0_we_i;
  logic [AW-1:0] m0_addr_i;
  logic [DW-1:0] m0_dat_i;
  logic [SW-1:0] m0_sel_i;
  logic [2:0]    m0_cti_i;
  logic [DW-1:0] m0_dat_o;
  logic          m0_ack_o, m0_err_o;
  logic          m1_cyc_i, m1_stb_i, m1_we_i;
  logic [AW-1:0] m1_addr_i;
  logic [DW-1:0] m1_dat_i;
  logic [SW-1:0] m1_sel_i;
  logic [2:0]    m1_cti_i;
  logic [DW-1:0] m1_dat_o;
  logic          m1_ack_o, m1_err_o;
  logic          s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0] s_addr_o;
  logic [DW-1:0] s_dat_o;
  logic [SW-1:0] s_sel_o;
  logic [2:0]    s_cti_o;
  logic [DW-1:0] s_dat_i;
  logic          s_ack_i;
  logic [1:0]    gnt_o;
  logic          timeout_o;

  int n_pass  = 0;
  int n_total = 0;

  sdrc_wb_arbiter #(.AW(AW), .DW(DW), .SW(SW), .TO_CYC(16), .CNT_W(5)) dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i),
    .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_cti_i(m0_cti_i), .m0_dat_o(m0_dat_o),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i),
    .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_cti_i(m1_cti_i), .m1_dat_o(m1_dat_o),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o),
    .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_cti_o(s_cti_o), .s_dat_i(s_dat_i),
    .s_ack_i(s_ack_i), .gnt_o(gnt_o), .timeout_o(timeout_o)
  );

  // One-word slave memory at address 0x10
  logic [DW-1:0] mem_word;
  always @(posedge clk) begin
    if (s_cyc_o && s_stb_o && s_we_o && s_ack_i && (s_addr_o == 26'h10)) mem_word <= s_dat_o;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clear_inputs();
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b0; m0_addr_i = '0;
    m0_dat_i = '0; m0_sel_i = 4'hF; m0_cti_i = 3'b000;
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0; m1_addr_i = '0;
    m1_dat_i = '0; m1_sel_i = 4'hF; m1_cti_i = 3'b000;
    s_ack_i = 1'b0; s_dat_i = '0;
  endtask

  task automatic wd_run(input bit ack_at_expiry);
    m0_cyc_i = 1'b1; m0_we_i = 1'b0; m0_addr_i = 26'h40;
    tick();
    m0_stb_i = 1'b1;
    for (int k = 0; k < 15; k++) begin
      settle();
      chk("wd_no_early_err", {m0_err_o, timeout_o, s_stb_o}, 3'b001);
      tick();
    end
    if (!ack_at_expiry) begin
      settle();
      chk("wd_err_pulse", m0_err_o, 1'b1);
      chk("wd_timeout_pulse", timeout_o, 1'b1);
      chk("wd_cyc_forced_low", {s_cyc_o, s_stb_o}, 2'b00);
      chk("wd_m1_err_quiet", m1_err_o, 1'b0);
      tick();
      s_ack_i = 1'b1;
      settle();
      chk("drain_late_ack_m0", m0_ack_o, 1'b0);
      chk("drain_late_ack_m1", m1_ack_o, 1'b0);
      chk("drain_err_once", {m0_err_o, timeout_o}, 2'b00);
      chk("drain_gnt", gnt_o, 2'b01);
      tick();
      settle();
      chk("drain_no_repeat", {timeout_o, s_cyc_o}, 2'b00);
    end else begin
      s_ack_i = 1'b1;
      settle();
      chk("wd_ack_wins_err", {m0_err_o, timeout_o}, 2'b00);
      chk("wd_ack_wins_ack", m0_ack_o, 1'b1);
      chk("wd_ack_wins_cyc", s_cyc_o, 1'b1);
    end
    tick();
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; s_ack_i = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    clear_inputs();
    wb_rst_i = 1'b1;
    #3;
    chk("rst_outputs", {s_cyc_o, s_stb_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, gnt_o, timeout_o}, 9'd0);
    m0_cyc_i = 1'b1; m1_cyc_i = 1'b1;
    tick();
    tick();
    chk("rst_holds_idle", {gnt_o, s_cyc_o}, 3'b000);
    clear_inputs();
    wb_rst_i = 1'b0;
    tick();

    // Single master write then read
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b1;
    m0_addr_i = 26'h10; m0_dat_i = 32'hDEADBEEF;
    settle();
    chk("grant_latency_idle", {s_cyc_o, gnt_o}, 3'b000);
    tick();
    settle();
    chk("grant_cyc", s_cyc_o, 1'b1);
    chk("grant_gnt01", gnt_o, 2'b01);
    chk("pass_addr", s_addr_o, 26'h10);
    chk("pass_wdata", s_dat_o, 32'hDEADBEEF);
    chk("ack_before_slave", m0_ack_o, 1'b0);
    s_ack_i = 1'b1;
    settle();
    chk("ack_same_cycle", m0_ack_o, 1'b1);
    chk("ack_other_quiet", m1_ack_o, 1'b0);
    tick();
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b0; s_ack_i = 1'b0;
    settle();
    chk("drop_cyc_pass", s_cyc_o, 1'b0);
    tick();
    settle();
    chk("idle_gnt00", gnt_o, 2'b00);
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    tick();
    s_dat_i = mem_word; s_ack_i = 1'b1;
    settle();
    chk("read_data", m0_dat_o, 32'hDEADBEEF);
    chk("read_ack", m0_ack_o, 1'b1);
    chk("read_other_dat0", m1_dat_o, 32'h0);
    tick();
    clear_inputs();
    tick();
    tick();

    // Simultaneous bursts from reset
    wb_rst_i = 1'b1;
    tick();
    wb_rst_i = 1'b0;
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_addr_i = 26'h100;
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_addr_i = 26'h200;
    tick();
    for (int b = 0; b < 4; b++) begin
      m0_addr_i = 26'h100 + 26'(4 * b);
      m0_cti_i  = (b == 3) ? 3'b111 : 3'b010;
      s_ack_i   = 1'b1;
      settle();
      chk("rr_m0_first_gnt", gnt_o, 2'b01);
      chk("rr_m0_ack", m0_ack_o, 1'b1);
      chk("rr_m1_no_ack", m1_ack_o, 1'b0);
      chk("rr_m0_addr", s_addr_o, 26'h100 + 26'(4 * b));
      tick();
    end
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; s_ack_i = 1'b0;
    settle();
    chk("rr_m0_release", {s_cyc_o, gnt_o}, 3'b001);
    tick();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_cti_i = 3'b000; m0_addr_i = 26'h180;
    for (int b = 0; b < 4; b++) begin
      m1_addr_i = 26'h200 + 26'(4 * b);
      m1_cti_i  = (b == 3) ? 3'b111 : 3'b010;
      s_ack_i   = 1'b1;
      settle();
      chk("rr_m1_gnt_no_gap", {gnt_o, s_cyc_o}, 3'b101);
      chk("rr_m1_ack", m1_ack_o, 1'b1);
      chk("rr_m0_waits", m0_ack_o, 1'b0);
      chk("rr_m1_addr", s_addr_o, 26'h200 + 26'(4 * b));
      chk("rr_m1_cti", s_cti_o, (b == 3) ? 3'b111 : 3'b010);
      tick();
    end
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0; s_ack_i = 1'b0;
    tick();
    settle();
    chk("rr_alternate_m0", gnt_o, 2'b01);
    chk("rr_alternate_addr", s_addr_o, 26'h180);
    clear_inputs();
    tick();
    tick();

    // Burst hold with stb gaps while m1 waits
    m0_cyc_i = 1'b1;
    tick();
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    for (int b = 0; b < 8; b++) begin
      m0_stb_i = 1'b1; s_ack_i = 1'b1;
      m0_cti_i = (b == 7) ? 3'b111 : 3'b010;
      settle();
      chk("hold_beat", {gnt_o, m0_ack_o, s_stb_o}, 4'b0111);
      tick();
      m0_stb_i = 1'b0; s_ack_i = 1'b0;
      settle();
      chk("hold_gap1", {gnt_o, s_stb_o}, 3'b010);
      tick();
      settle();
      chk("hold_gap2", gnt_o, 2'b01);
      tick();
    end
    m0_cyc_i = 1'b0;
    settle();
    chk("hold_drop_cycle", gnt_o, 2'b01);
    tick();
    settle();
    chk("hold_handover", gnt_o, 2'b10);
    clear_inputs();
    tick();
    tick();

    // Watchdog expiry and ack-wins boundary
    wd_run(1'b0);
    wd_run(1'b1);

    // Asynchronous reset during beat 3
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_cti_i = 3'b010;
    tick();
    for (int b = 0; b < 2; b++) begin
      s_ack_i = 1'b1;
      tick();
    end
    s_dat_i = 32'hA5A5A5A5;
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    settle();
    chk("midburst_ack", m0_ack_o, 1'b1);
    #1 wb_rst_i = 1'b1;
    #1;
    chk("async_rst_outputs", {s_cyc_o, s_stb_o, m0_ack_o, m1_ack_o, m0_err_o, gnt_o, timeout_o}, 8'd0);
    chk("async_rst_dat", m0_dat_o, 32'h0);
    @(posedge clk);
    #1 wb_rst_i = 1'b0;
    s_ack_i = 1'b0;
    settle();
    chk("post_rst_idle", gnt_o, 2'b00);
    tick();
    settle();
    chk("post_rst_m0_first", {gnt_o, s_cyc_o}, 3'b011);
    clear_inputs();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sdrc_wb_arbiter.md
Name: sdrc_wb_arbiter

Overview:
- Two-master Wishbone arbiter placed in front of the SDRAM controller's single Wishbone slave port.
- Shares that port between two requesters, for example a CPU path and a DMA/test master.
- Uses round-robin arbitration. A grant is held for a whole cycle, including CTI incrementing bursts, until the owning master drops cyc.
- An optional watchdog terminates a stalled access with an error to the master, so a hung controller cannot lock the bus.

Parameters:
AW  26  Wishbone address width
DW  32  Wishbone data width
SW  DW/8  byte-select width
TO_CYC  256  cycles of stb-without-ack before timeout; 0 disables the watchdog
CNT_W  9  watchdog counter width; must satisfy 2^CNT_W > TO_CYC

Ports:
wb_clk_i  in  1  system clock; all logic on the rising edge
wb_rst_i  in  1  reset, asynchronous, active-high
m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 control
m0_addr_i  in  AW  master 0 address
m0_dat_i  in  DW  master 0 write data
m0_sel_i  in  SW  master 0 byte selects
m0_cti_i  in  3  master 0 cycle type
m0_dat_o  out  DW  master 0 read data
m0_ack_o, m0_err_o  out  1 each  master 0 termination
m1_*  same set as m0_*  master 1
s_cyc_o, s_stb_o, s_we_o  out  1 each  to controller
s_addr_o  out  AW  to controller
s_dat_o  out  DW  to controller
s_sel_o  out  SW  to controller
s_cti_o  out  3  to controller
s_dat_i  in  DW  from controller
s_ack_i  in  1  from controller
gnt_o  out  2  one-hot current owner; 00 when idle
timeout_o  out  1  one-cycle pulse on each watchdog expiry

Behaviour:
- Clocking and reset:
  - One clock, wb_clk_i.
  - wb_rst_i is asynchronous and active-high.
  - While in reset: state=IDLE, last_gnt=1 (so master 0 wins the first tie), watchdog=0.
  - All outputs are 0 during reset, including s_cyc_o, s_stb_o, every ack/err, gnt_o and timeout_o.
  - Asserting reset mid-burst drops s_cyc_o and s_stb_o immediately; no ack is forwarded.
- States: IDLE, GNT0, GNT1, DRAIN0, DRAIN1.
- IDLE:
  - All slave outputs are 0; gnt_o=00.
  - Request from one master only: go to GNTx on the next edge.
  - Both masters requesting: grant the master that is not last_gnt.
  - Grant latency: m_cyc rise to s_cyc_o rise is exactly 1 cycle.
- GNTx:
  - All s_* outputs are a combinational pass-through of mx_*.
  - mx_ack_o = s_ack_i; mx_dat_o = s_dat_i.
  - The other master sees ack=0 and err=0, and its dat_o is 0.
  - The state is held while mx_cyc_i=1, regardless of stb gaps or the cti value.
  - On the first cycle with mx_cyc_i=0, s_cyc_o is already 0 because it is passed through, and last_gnt is set to x.
  - Next state from that cycle: GNTy if the other master has cyc high, otherwise IDLE.
  - Handover to a waiting master therefore costs no idle cycle.
- Watchdog:
  - Active only in GNTx with TO_CYC>0.
  - Counts cycles where s_stb_o=1 and s_ack_i=0.
  - Clears to 0 on s_ack_i=1, on s_stb_o=0, and on any state change.
  - When the count equals TO_CYC-1 and s_ack_i=0, in that same cycle:
    - assert mx_err_o=1 for that cycle only;
    - assert timeout_o=1;
    - force s_cyc_o and s_stb_o to 0;
    - go to DRAINx.
  - If s_ack_i arrives in the expiry cycle, the ack wins: no error is raised.
- DRAINx:
  - Slave outputs are 0.
  - s_ack_i is ignored, so a late ack never reaches either master; mx_ack_o=0 and mx_err_o=0.
  - Leave when mx_cyc_i=0, with last_gnt=x and the same re-arbitration as GNTx exit.
- Invariants:
  - gnt_o is one-hot in GNTx and DRAINx.
  - ack and err are never both high.
  - At most one master sees ack or err in any cycle.
- Latency: zero added data-path latency once granted. ack, dat and err paths are combinational; state, last_gnt, watchdog and timeout qualification are registered.

Test Plan:
- Single master: m0 writes 0xDEADBEEF to address 0x10, then reads it back. Required: s_cyc_o rises 1 cycle after m0_cyc_i; m0_ack_o follows s_ack_i in the same cycle; read data is 0xDEADBEEF; gnt_o=01 while granted, then 00.
- Simultaneous requests from reset: both cyc rise together, each doing a 4-beat incrementing burst (cti=010, last beat 111). Required:
  - m0 is served first, then m1 with no idle cycle between them;
  - m1 sees no ack during m0's burst;
  - m0 then requests again while m1 is busy and is served after m1, confirming alternation.
- Burst hold: m0 runs an 8-beat burst with stb gaps of 2 cycles while m1 keeps cyc high. Required: gnt_o stays 01 until m0_cyc_i falls, then changes to 10 on the next edge.
- Watchdog: TO_CYC=16 and the slave never acks. Required:
  - m0_err_o and timeout_o pulse once, exactly 16 cycles after stb rises;
  - s_cyc_o is 0 in that cycle;
  - a late s_ack_i injected during DRAIN0 is not seen on m0_ack_o or m1_ack_o.
- Reset mid-burst: assert wb_rst_i asynchronously between clock edges during beat 3 of a burst. Required:
  - all outputs go to 0 before the next edge;
  - after release with both masters requesting, m0 is granted first.
